// File: rtl/serial_alu.sv
// serial_alu: digit-serial NOR/XOR/ADD/SUB, DIGIT bits per clock, LSB first.
// Start/busy/done handshake; s/cout/zero update only on the done edge.
module serial_alu #(
  parameter int WIDTH = 64,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_chk
    $error("serial_alu: DIGIT must divide WIDTH");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rs_nxt;
  logic [1:0]       rop;
  logic             carry;
  logic             carry_nxt;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             is_nor;
  logic             is_xor;
  logic             is_add;
  logic             is_sub;
  logic [DIGIT-1:0] ad;
  logic [DIGIT-1:0] bd;
  logic [DIGIT-1:0] dig;
  logic [DIGIT:0]   sum;
  logic [WIDTH+DIGIT-1:0] cat;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (last)  state_nxt = IDLE;
    endcase
  end

  // outputs decoded from the state register
  always_comb begin
    busy = (state == RUN);
  end

  // one digit slice; logical ops leave the carry at 0 so cout reads 0
  always_comb begin
    is_nor = (rop == 2'b00);
    is_xor = (rop == 2'b01);
    is_add = (rop == 2'b10);
    is_sub = (rop == 2'b11);
    ad  = ra[DIGIT-1:0];
    bd  = is_sub ? ~rb[DIGIT-1:0] : rb[DIGIT-1:0];
    sum = {1'b0, ad} + {1'b0, bd}
        + {{DIGIT{1'b0}}, carry};
    dig       = '0;
    carry_nxt = 1'b0;
    unique case (1'b1)
      is_nor: dig = ~(ad | bd);
      is_xor: dig = ad ^ bd;
      is_add, is_sub: begin
        dig       = sum[DIGIT-1:0];
        carry_nxt = sum[DIGIT];
      end
    endcase
    cat    = {dig, rs};
    rs_nxt = cat[WIDTH+DIGIT-1:DIGIT];
    last   = (cnt == LAST);
  end

  // operand/result shifting and result publication
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ra    <= '0;
      rb    <= '0;
      rs    <= '0;
      rop   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
      zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          ra    <= a;
          rb    <= b;
          rop   <= op;
          carry <= (op == 2'b11);
          cnt   <= '0;
        end
      end else begin
        ra    <= ra >> DIGIT;
        rb    <= rb >> DIGIT;
        rs    <= rs_nxt;
        carry <= carry_nxt;
        cnt   <= cnt + 1'b1;
        if (last) begin
          s    <= rs_nxt;
          cout <= carry_nxt;
          zero <= (rs_nxt == '0);
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_alu.sv
// tb_serial_alu: four serial_alu instances (8/1, 8/2, 64/1, 64/8)
// checked against an arithmetic reference model.
module tb_serial_alu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  start;
  logic [63:0] a;
  logic [63:0] b;
  logic [1:0]  op;
  logic [3:0]  busy_v;
  logic [3:0]  done_v;
  logic [3:0]  cout_v;
  logic [3:0]  zero_v;
  logic [7:0]  s0;
  logic [7:0]  s1;
  logic [63:0] s2;
  logic [63:0] s3;
  logic [63:0] s_v [4];

  int n_cmp = 0;
  int n_err = 0;

  assign s_v[0] = {56'd0, s0};
  assign s_v[1] = {56'd0, s1};
  assign s_v[2] = s2;
  assign s_v[3] = s3;

  serial_alu #(.WIDTH(8), .DIGIT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]),
    .a(a[7:0]), .b(b[7:0]), .op(op),
    .busy(busy_v[0]), .done(done_v[0]), .s(s0),
    .cout(cout_v[0]), .zero(zero_v[0]));

  serial_alu #(.WIDTH(8), .DIGIT(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]),
    .a(a[7:0]), .b(b[7:0]), .op(op),
    .busy(busy_v[1]), .done(done_v[1]), .s(s1),
    .cout(cout_v[1]), .zero(zero_v[1]));

  serial_alu #(.WIDTH(64), .DIGIT(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]),
    .a(a), .b(b), .op(op),
    .busy(busy_v[2]), .done(done_v[2]), .s(s2),
    .cout(cout_v[2]), .zero(zero_v[2]));

  serial_alu #(.WIDTH(64), .DIGIT(8)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start[3]),
    .a(a), .b(b), .op(op),
    .busy(busy_v[3]), .done(done_v[3]), .s(s3),
    .cout(cout_v[3]), .zero(zero_v[3]));

  // Whole-word reference: result plus carry bit at position w
  function automatic void model(
    input int w, input logic [63:0] x, input logic [63:0] y,
    input logic [1:0] o, output logic [63:0] es, output logic ec);
    logic [64:0] m;
    logic [64:0] xa;
    logic [64:0] ya;
    logic [64:0] r;
    m  = (65'd1 << w) - 65'd1;
    xa = {1'b0, x} & m;
    ya = {1'b0, y} & m;
    case (o)
      2'b00:   r = ~(xa | ya) & m;
      2'b01:   r = xa ^ ya;
      2'b10:   r = xa + ya;
      default: r = xa + (~ya & m) + 65'd1;
    endcase
    es = r[63:0] & m[63:0];
    ec = r[w];
  endfunction

  // Drives one operation from a negedge; returns at the negedge where done
  // is seen (or after limit cycles with lat = -1). No checking here.
  task automatic run_op(
    input int idx, input logic [63:0] xa, input logic [63:0] xb,
    input logic [1:0] o, input int limit,
    output int lat, output bit bsy_ok, output bit d0, output bit stable);
    logic [63:0] s_init;
    a = xa;
    b = xb;
    op = o;
    start[idx] = 1'b1;
    @(negedge clk);
    start[idx] = 1'b0;
    lat = 0;
    bsy_ok = 1'b1;
    stable = 1'b1;
    d0 = done_v[idx];
    s_init = s_v[idx];
    while (done_v[idx] !== 1'b1 && lat < limit) begin
      if (busy_v[idx] !== 1'b1) bsy_ok = 1'b0;
      if (s_v[idx] !== s_init) stable = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (done_v[idx] !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = '0;
    a = '0;
    b = '0;
    op = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({busy_v[i], done_v[i], cout_v[i], zero_v[i], s_v[i]} !== 68'd0) begin
        n_err++;
        $display("FAIL reset[%0d]: got b%b d%b c%b z%b s=%h want all 0",
                 i, busy_v[i], done_v[i], cout_v[i], zero_v[i], s_v[i]);
      end
    end
  endtask

  task automatic test_add_wrap();
    int lat;
    bit bo, d0, st;
    run_op(0, 64'hFF, 64'h01, 2'b10, 20, lat, bo, d0, st);
    n_cmp++;
    if (lat !== 8) begin
      n_err++;
      $display("FAIL add_wrap_lat: got %0d want 8", lat);
    end
    n_cmp++;
    if ({bo, busy_v[0]} !== 2'b10) begin
      n_err++;
      $display("FAIL add_wrap_busy: got run_ok=%b busy_at_done=%b want 1/0",
               bo, busy_v[0]);
    end
    n_cmp++;
    if ({s_v[0], cout_v[0], zero_v[0]} !== {64'h00, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL add_wrap_res: got s=%h c=%b z=%b want 00/1/1",
               s_v[0], cout_v[0], zero_v[0]);
    end
    @(negedge clk);
    n_cmp++;
    if (done_v[0] !== 1'b0) begin
      n_err++;
      $display("FAIL add_wrap_pulse: got done=%b want 0", done_v[0]);
    end
  endtask

  task automatic test_sub();
    int lat;
    bit bo, d0, st;
    run_op(0, 64'h05, 64'h07, 2'b11, 20, lat, bo, d0, st);
    n_cmp++;
    if ({lat, s_v[0], cout_v[0], zero_v[0]} !== {32'd8, 64'hFE, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL sub_borrow: got lat=%0d s=%h c=%b z=%b want 8/fe/0/0",
               lat, s_v[0], cout_v[0], zero_v[0]);
    end
    @(negedge clk);
    run_op(0, 64'h07, 64'h05, 2'b11, 20, lat, bo, d0, st);
    n_cmp++;
    if ({lat, s_v[0], cout_v[0], zero_v[0]} !== {32'd8, 64'h02, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL sub_noborrow: got lat=%0d s=%h c=%b z=%b want 8/02/1/0",
               lat, s_v[0], cout_v[0], zero_v[0]);
    end
    @(negedge clk);
  endtask

  task automatic test_logic_d2();
    int lat;
    bit bo, d0, st;
    run_op(1, 64'h0F, 64'h30, 2'b00, 20, lat, bo, d0, st);
    n_cmp++;
    if ({lat, s_v[1], cout_v[1], zero_v[1]} !== {32'd4, 64'hC0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL nor_d2: got lat=%0d s=%h c=%b z=%b want 4/c0/0/0",
               lat, s_v[1], cout_v[1], zero_v[1]);
    end
    @(negedge clk);
    run_op(1, 64'hAA, 64'hFF, 2'b01, 20, lat, bo, d0, st);
    n_cmp++;
    if ({lat, s_v[1], cout_v[1], zero_v[1]} !== {32'd4, 64'h55, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL xor_d2: got lat=%0d s=%h c=%b z=%b want 4/55/0/0",
               lat, s_v[1], cout_v[1], zero_v[1]);
    end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    int k;
    bit quiet;
    a = 64'h10;
    b = 64'h20;
    op = 2'b10;
    start[0] = 1'b1;
    @(negedge clk);
    k = 0;
    while (done_v[0] !== 1'b1 && k < 20) begin
      a = (k % 2 == 1) ? 64'hFF : 64'h00;
      b = (k % 2 == 1) ? 64'hFF : 64'h00;
      op = 2'b00;
      @(negedge clk);
      k++;
    end
    start[0] = 1'b0;
    n_cmp++;
    if ({k, s_v[0], cout_v[0]} !== {32'd8, 64'h30, 1'b0}) begin
      n_err++;
      $display("FAIL busy_ignore: got lat=%0d s=%h c=%b want 8/30/0",
               k, s_v[0], cout_v[0]);
    end
    quiet = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) quiet = 1'b0;
    end
    n_cmp++;
    if (quiet !== 1'b1) begin
      n_err++;
      $display("FAIL no_second_op: got quiet=%b want 1", quiet);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit bo, d0, st;
    run_op(0, 64'h01, 64'h02, 2'b10, 20, lat, bo, d0, st);
    n_cmp++;
    if ({lat, s_v[0]} !== {32'd8, 64'h03}) begin
      n_err++;
      $display("FAIL b2b_first: got lat=%0d s=%h want 8/03", lat, s_v[0]);
    end
    run_op(0, 64'h03, 64'h04, 2'b10, 20, lat, bo, d0, st);
    n_cmp++;
    if ({d0, bo, st, lat, s_v[0]} !== {3'b011, 32'd8, 64'h07}) begin
      n_err++;
      $display("FAIL b2b_second: got d0=%b busy=%b hold=%b lat=%0d s=%h want 0/1/1/8/07",
               d0, bo, st, lat, s_v[0]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat;
    bit bo, d0, st, quiet;
    a = 64'h11;
    b = 64'h22;
    op = 2'b10;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++;
    if ({busy_v[0], s_v[0], cout_v[0], zero_v[0]} !== 67'd0) begin
      n_err++;
      $display("FAIL reset_mid: got b=%b s=%h c=%b z=%b want 0/0/0/0",
               busy_v[0], s_v[0], cout_v[0], zero_v[0]);
    end
    quiet = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) quiet = 1'b0;
    end
    n_cmp++;
    if (quiet !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_nodone: got quiet=%b want 1", quiet);
    end
    run_op(0, 64'h7F, 64'h01, 2'b10, 20, lat, bo, d0, st);
    n_cmp++;
    if ({lat, s_v[0], cout_v[0], zero_v[0]} !== {32'd8, 64'h80, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_mid_after: got lat=%0d s=%h c=%b z=%b want 8/80/0/0",
               lat, s_v[0], cout_v[0], zero_v[0]);
    end
    @(negedge clk);
  endtask

  task automatic test_random(input int idx, input int nops, input int nlat);
    int lat;
    bit bo, d0, st;
    logic [63:0] xa, xb, es;
    logic ec;
    logic [1:0] o;
    for (int i = 0; i < nops; i++) begin
      xa = {$urandom, $urandom};
      xb = {$urandom, $urandom};
      o = 2'($urandom_range(3));
      if (i % 8 == 3) xb = xa;
      if (i % 8 == 5) xb = ~xa;
      model(64, xa, xb, o, es, ec);
      run_op(idx, xa, xb, o, nlat + 5, lat, bo, d0, st);
      n_cmp++;
      if (lat !== nlat || bo !== 1'b1 || st !== 1'b1) begin
        n_err++;
        $display("FAIL rand%0d_lat: got lat=%0d busy=%b hold=%b want %0d/1/1",
                 idx, lat, bo, st, nlat);
      end
      n_cmp++;
      if (s_v[idx] !== es) begin
        n_err++;
        $display("FAIL rand%0d_s: op=%0d a=%h b=%h got %h want %h",
                 idx, o, xa, xb, s_v[idx], es);
      end
      n_cmp++;
      if (cout_v[idx] !== ec) begin
        n_err++;
        $display("FAIL rand%0d_cout: op=%0d a=%h b=%h got %b want %b",
                 idx, o, xa, xb, cout_v[idx], ec);
      end
      n_cmp++;
      if (zero_v[idx] !== (es == 64'd0)) begin
        n_err++;
        $display("FAIL rand%0d_zero: got %b want %b",
                 idx, zero_v[idx], (es == 64'd0));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_sub();
    test_logic_d2();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random(2, 400, 64);
    test_random(3, 1000, 8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
